// File: rtl/pc_gen_if.sv
// Fetch-side bundle of pc_gen: control/target inputs and fetch PC outputs.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            fetch_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            trap;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] ret_target;
  logic            fetch_valid;
  logic [XLEN-1:0] pc_out;
  logic            misaligned;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    input  stall, fetch_ready, redirect, redirect_target, trap, call, ret, ret_target,
    output fetch_valid, pc_out, misaligned, ras_empty, ras_full
  );

  modport slave (
    output stall, fetch_ready, redirect, redirect_target, trap, call, ret, ret_target,
    input  fetch_valid, pc_out, misaligned, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator: trap/redirect priority, stall, fetch handshake,
// and a circular return-address stack for call/return prediction.
module pc_gen #(
  parameter int unsigned            XLEN         = 32,
  parameter logic [XLEN-1:0]        RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]        TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned            INC          = 4,
  parameter int unsigned            RAS_DEPTH    = 4
) (
  input logic       clk,
  input logic       reset,
  pc_gen_if.master  bus
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] pc_q, pc_next;
  logic            valid_q;
  logic            misaligned_q;
  logic [PW-1:0]   ptr_q, ptr_next;
  logic [CW-1:0]   cnt_q, cnt_next;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];

  logic            fire, ras_ok, do_call, do_ret, empty, full;
  logic [XLEN-1:0] pc_seq, ras_top;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;

  // Next-PC selection and RAS bookkeeping
  always_comb begin
    pc_next  = pc_q;
    ptr_next = ptr_q;
    cnt_next = cnt_q;
    wr_en    = 1'b0;
    wr_idx   = ptr_q;

    pc_seq  = pc_q + XLEN'(INC);
    fire    = valid_q & bus.fetch_ready & ~bus.stall;
    ras_ok  = fire & ~bus.trap & ~bus.redirect;
    do_call = ras_ok & bus.call;
    do_ret  = ras_ok & bus.ret;
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(RAS_DEPTH));
    ras_top = empty ? bus.ret_target : ras_mem[ptr_q];

    if (bus.trap)          pc_next = TRAP_VECTOR;
    else if (bus.redirect) pc_next = bus.redirect_target;
    else if (do_ret)       pc_next = ras_top;
    else if (fire)         pc_next = pc_seq;

    // Empty-stack call+ret degenerates to a plain push.
    if (do_call && (!do_ret || empty)) begin
      wr_en    = 1'b1;
      wr_idx   = ptr_q + PW'(1);
      ptr_next = ptr_q + PW'(1);
      if (!full) cnt_next = cnt_q + CW'(1);
    end else if (do_call && do_ret) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
    end else if (do_ret && !empty) begin
      ptr_next = ptr_q - PW'(1);
      cnt_next = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= RESET_VECTOR;
      valid_q      <= 1'b0;
      misaligned_q <= (RESET_VECTOR[1:0] != 2'b00);
      ptr_q        <= '0;
      cnt_q        <= '0;
    end else begin
      pc_q         <= pc_next;
      valid_q      <= 1'b1;
      misaligned_q <= (pc_next[1:0] != 2'b00);
      ptr_q        <= ptr_next;
      cnt_q        <= cnt_next;
    end
  end

  // Entry contents carry no reset; occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (reset && wr_en) ras_mem[wr_idx] <= pc_seq;
  end

  assign bus.pc_out      = pc_q;
  assign bus.fetch_valid = valid_q;
  assign bus.misaligned  = misaligned_q;
  assign bus.ras_empty   = empty;
  assign bus.ras_full    = full;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized run
// against a queue-based reference model.
module tb_pc_gen;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ras[$];

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(
    .XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .INC(4), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.stall = 0; bus.fetch_ready = 1; bus.redirect = 0; bus.redirect_target = '0;
    bus.trap = 0; bus.call = 0; bus.ret = 0; bus.ret_target = '0;
  endtask

  // Advance the reference model by one edge from current inputs, then clock the DUT.
  task automatic tick();
    logic        f;
    logic [31:0] seq, top;
    if (!reset) begin
      m_pc = RV; m_valid = 0; m_ras.delete();
    end else begin
      f   = m_valid & bus.fetch_ready & ~bus.stall;
      seq = m_pc + 32'd4;
      if (bus.trap) m_pc = TV;
      else if (bus.redirect) m_pc = bus.redirect_target;
      else if (f) begin
        top = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : bus.ret_target;
        if (bus.call && bus.ret) begin
          if (m_ras.size() > 0) m_ras[m_ras.size()-1] = seq;
          else m_ras.push_back(seq);
          m_pc = top;
        end else if (bus.call) begin
          m_ras.push_back(seq);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
          m_pc = seq;
        end else if (bus.ret) begin
          if (m_ras.size() > 0) void'(m_ras.pop_back());
          m_pc = top;
        end else m_pc = seq;
      end
      m_valid = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    bus.redirect = 1; bus.redirect_target = t; tick();
    bus.redirect = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    tick(); tick();
    n_checks++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.fetch_valid); end
    n_checks++; if (bus.pc_out !== RV) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", bus.pc_out, RV); end
    n_checks++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin n_fail++; $display("FAIL reset_ras got=%b%b exp=10", bus.ras_empty, bus.ras_full); end
    n_checks++; if (bus.misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned got=%b exp=0", bus.misaligned); end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8; exp_seq[3] = 32'hC;
    reset = 1;
    tick();
    n_checks++; if (bus.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL run_valid got=%b exp=1", bus.fetch_valid); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.pc_out !== exp_seq[i]) begin n_fail++; $display("FAIL run_pc%0d got=%h exp=%h", i, bus.pc_out, exp_seq[i]); end
      if (i < 2) tick();
    end
  endtask

  task automatic test_stall();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.pc_out !== 32'h8) begin n_fail++; $display("FAIL stall_hold%0d got=%h exp=00000008", i, bus.pc_out); end
    end
    bus.stall = 0; bus.fetch_ready = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (bus.pc_out !== 32'h8) begin n_fail++; $display("FAIL backpressure_hold%0d got=%h exp=00000008", i, bus.pc_out); end
    end
    bus.fetch_ready = 1;
    tick();
    n_checks++; if (bus.pc_out !== 32'hC) begin n_fail++; $display("FAIL stall_release got=%h exp=0000000c", bus.pc_out); end
  endtask

  task automatic test_priority();
    bus.trap = 1; bus.redirect = 1; bus.redirect_target = 32'h2000; bus.ret = 1; bus.ret_target = 32'h7770;
    tick();
    clear_inputs();
    n_checks++; if (bus.pc_out !== TV) begin n_fail++; $display("FAIL prio_trap got=%h exp=%h", bus.pc_out, TV); end
    n_checks++; if (bus.ras_empty !== 1'b1) begin n_fail++; $display("FAIL prio_ras got=%b exp=1", bus.ras_empty); end
    redirect_to(32'h2002);
    n_checks++; if (bus.pc_out !== 32'h2002) begin n_fail++; $display("FAIL redirect_pc got=%h exp=00002002", bus.pc_out); end
    n_checks++; if (bus.misaligned !== 1'b1) begin n_fail++; $display("FAIL redirect_misaligned got=%b exp=1", bus.misaligned); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] rets [5];
    rets[0] = 32'h54; rets[1] = 32'h44; rets[2] = 32'h34; rets[3] = 32'h24; rets[4] = 32'hDEAD0;
    for (int i = 1; i <= 5; i++) begin
      redirect_to(32'(i * 16));
      bus.call = 1; tick(); bus.call = 0;
      n_checks++; if (bus.pc_out !== 32'(i * 16 + 4)) begin n_fail++; $display("FAIL call%0d_pc got=%h exp=%h", i, bus.pc_out, 32'(i * 16 + 4)); end
      if (i >= 4) begin
        n_checks++; if (bus.ras_full !== 1'b1) begin n_fail++; $display("FAIL call%0d_full got=%b exp=1", i, bus.ras_full); end
      end
    end
    bus.ret = 1; bus.ret_target = 32'hDEAD0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (bus.pc_out !== rets[i]) begin n_fail++; $display("FAIL ret%0d_pc got=%h exp=%h", i, bus.pc_out, rets[i]); end
    end
    bus.ret = 0;
    n_checks++; if (bus.ras_empty !== 1'b1) begin n_fail++; $display("FAIL underflow_empty got=%b exp=1", bus.ras_empty); end
  endtask

  task automatic test_call_ret();
    redirect_to(32'h20);
    bus.call = 1; tick(); bus.call = 0;
    redirect_to(32'h60);
    bus.call = 1; bus.ret = 1; tick(); bus.call = 0;
    n_checks++; if (bus.pc_out !== 32'h24) begin n_fail++; $display("FAIL callret_pc got=%h exp=00000024", bus.pc_out); end
    n_checks++; if (bus.ras_empty !== 1'b0) begin n_fail++; $display("FAIL callret_count got=%b exp=0", bus.ras_empty); end
    bus.ret_target = 32'hBAD0; tick(); bus.ret = 0;
    n_checks++; if (bus.pc_out !== 32'h64) begin n_fail++; $display("FAIL callret_top got=%h exp=00000064", bus.pc_out); end
    n_checks++; if (bus.ras_empty !== 1'b1) begin n_fail++; $display("FAIL callret_pop got=%b exp=1", bus.ras_empty); end
  endtask

  task automatic test_wrap_and_reset();
    redirect_to(32'hFFFF_FFFC);
    tick();
    n_checks++; if (bus.pc_out !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got=%h exp=00000000", bus.pc_out); end
    bus.call = 1; tick(); tick(); tick(); bus.call = 0;
    n_checks++; if (bus.ras_empty !== 1'b0) begin n_fail++; $display("FAIL pre_reset_ras got=%b exp=0", bus.ras_empty); end
    reset = 0; tick();
    n_checks++; if (bus.pc_out !== RV || bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL midreset got=%h/%b exp=%h/0", bus.pc_out, bus.fetch_valid, RV); end
    n_checks++; if (bus.ras_empty !== 1'b1) begin n_fail++; $display("FAIL midreset_ras got=%b exp=1", bus.ras_empty); end
    reset = 1; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset               = ($urandom_range(0, 59) != 0);
      bus.stall           = ($urandom_range(0, 3) == 0);
      bus.fetch_ready     = ($urandom_range(0, 3) != 0);
      bus.trap            = ($urandom_range(0, 31) == 0);
      bus.redirect        = ($urandom_range(0, 15) == 0);
      bus.redirect_target = $urandom();
      bus.call            = ($urandom_range(0, 3) == 0);
      bus.ret             = ($urandom_range(0, 3) == 0);
      bus.ret_target      = $urandom();
      tick();
      n_checks++; if (bus.pc_out !== m_pc) begin n_fail++; $display("FAIL rnd%0d_pc got=%h exp=%h", i, bus.pc_out, m_pc); end
      n_checks++; if (bus.fetch_valid !== m_valid) begin n_fail++; $display("FAIL rnd%0d_valid got=%b exp=%b", i, bus.fetch_valid, m_valid); end
      n_checks++; if (bus.misaligned !== (m_pc[1:0] != 2'b00)) begin n_fail++; $display("FAIL rnd%0d_misaligned got=%b", i, bus.misaligned); end
      n_checks++; if (bus.ras_empty !== (m_ras.size() == 0)) begin n_fail++; $display("FAIL rnd%0d_empty got=%b size=%0d", i, bus.ras_empty, m_ras.size()); end
      n_checks++; if (bus.ras_full !== (m_ras.size() == DEPTH)) begin n_fail++; $display("FAIL rnd%0d_full got=%b size=%0d", i, bus.ras_full, m_ras.size()); end
    end
  endtask

  initial begin
    reset = 0;
    m_pc = RV; m_valid = 0;
    test_reset();
    test_free_run();
    test_stall();
    test_priority();
    test_ras_overflow();
    test_call_ret();
    test_wrap_and_reset();
    clear_inputs();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
